// File: rtl/display_pkg.sv
// Shared constants and helpers for the seven-segment display blocks.
package display_pkg;

    localparam int DEF_NUM_DIGITS = 6;
    localparam int DEF_SEG_W      = 8;

    // Segment level driven on every line while a digit is blanked.
    localparam logic SEG_BLANK_BIT = 1'b0;

    // Map a logical "anode on" to the pin level for the board's polarity.
    function automatic logic an_level(input logic active, input logic active_low);
        return active ^ active_low;
    endfunction

endpackage

// File: rtl/scan_next_sel.sv
// Circular priority search for the next enabled digit after the current one.
module scan_next_sel
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int SEL_W      = 3
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [SEL_W-1:0]      next_sel,
    output logic                  wrapped
);

    int               idx;
    logic [SEL_W-1:0] cand;
    logic             found;

    // Search sel+1 .. sel+NUM_DIGITS so a lone enabled digit finds itself last.
    always_comb begin
        next_sel = sel;
        wrapped  = 1'b0;
        found    = 1'b0;
        idx      = 0;
        cand     = '0;
        for (int i = 1; i <= NUM_DIGITS; i++) begin
            idx  = (int'(sel) + i) % NUM_DIGITS;
            cand = SEL_W'(idx);
            if (!found && digit_mask[cand]) begin
                found    = 1'b1;
                next_sel = cand;
                wrapped  = (idx <= int'(sel));
            end
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed digit scan controller: slot prescaler, masked digit walk,
// anode decode with leading blanking guard, and frame marker.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS    = DEF_NUM_DIGITS,
    parameter int SEL_W         = 3,
    parameter int SEG_W         = DEF_SEG_W,
    parameter int PRESCALE      = 128,
    parameter int BLANK_CYCLES  = 8,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic                        CLK_12,
    input  logic                        CR,
    input  logic                        en,
    input  logic [NUM_DIGITS-1:0]       digit_mask,
    input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
    output logic [SEL_W-1:0]            sel,
    output logic [NUM_DIGITS-1:0]       an,
    output logic [SEG_W-1:0]            seg_out,
    output logic                        frame_start
);

    localparam int                    PCNT_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCNT_W-1:0]     PCNT_LAST  = PCNT_W'(PRESCALE - 1);
    localparam logic [PCNT_W-1:0]     PCNT_BLANK = PCNT_W'(BLANK_CYCLES);
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [PCNT_W-1:0]     pcnt_q, pcnt_d;
    logic [SEL_W-1:0]      sel_d, search_sel;
    logic                  search_wrapped, boundary, lit, fs_d;
    logic [NUM_DIGITS-1:0] an_d;
    logic [SEG_W-1:0]      seg_d;

    scan_next_sel #(
        .NUM_DIGITS (NUM_DIGITS),
        .SEL_W      (SEL_W)
    ) u_next_sel (
        .sel        (sel),
        .digit_mask (digit_mask),
        .next_sel   (search_sel),
        .wrapped    (search_wrapped)
    );

    // Outputs are computed from next-state values so sel, an and seg_out stay aligned.
    always_comb begin
        boundary = en && (pcnt_q == PCNT_LAST);
        pcnt_d   = pcnt_q;
        sel_d    = sel;
        fs_d     = 1'b0;
        if (boundary) begin
            pcnt_d = '0;
            if (|digit_mask) begin
                sel_d = search_sel;
                fs_d  = search_wrapped;
            end
        end else if (en) begin
            pcnt_d = pcnt_q + 1'b1;
        end

        lit  = en && digit_mask[sel_d] && (pcnt_d >= PCNT_BLANK);
        an_d = AN_OFF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_d[i] = an_level(lit && (sel_d == SEL_W'(i)), AN_ACTIVE_LOW);
        end
        seg_d = lit ? seg_in[sel_d*SEG_W +: SEG_W] : {SEG_W{SEG_BLANK_BIT}};
    end

    always_ff @(posedge CLK_12) begin
        if (CR) begin
            pcnt_q      <= '0;
            sel         <= '0;
            an          <= AN_OFF;
            seg_out     <= {SEG_W{SEG_BLANK_BIT}};
            frame_start <= 1'b0;
        end else begin
            pcnt_q      <= pcnt_d;
            sel         <= sel_d;
            an          <= an_d;
            seg_out     <= seg_d;
            frame_start <= fs_d;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed self-checking bench for display_scan_ctrl (6 digits, 4-cycle slots, 1 blank cycle).
module tb_display_scan_ctrl;

    logic        CLK_12 = 1'b0;
    logic        CR = 1'b0;
    logic        en = 1'b0;
    logic [5:0]  digit_mask = 6'b111111;
    logic [47:0] seg_in;
    logic [2:0]  sel;
    logic [5:0]  an;
    logic [7:0]  seg_out;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;
    int s;
    bit act;
    int tbl[3] = '{0, 2, 5};

    always #5 CLK_12 = ~CLK_12;

    display_scan_ctrl #(
        .NUM_DIGITS    (6),
        .SEL_W         (3),
        .SEG_W         (8),
        .PRESCALE      (4),
        .BLANK_CYCLES  (1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .CLK_12      (CLK_12),
        .CR          (CR),
        .en          (en),
        .digit_mask  (digit_mask),
        .seg_in      (seg_in),
        .sel         (sel),
        .an          (an),
        .seg_out     (seg_out),
        .frame_start (frame_start)
    );

    task automatic tick();
        @(posedge CLK_12);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        CR = 1'b1;
        tick();
        CR = 1'b0;
    endtask

    function automatic logic [5:0] an_exp(input int d, input bit on);
        return on ? ~(6'(1) << d) : 6'h3F;
    endfunction

    function automatic logic [7:0] seg_exp(input int d, input bit on);
        return on ? seg_in[d*8 +: 8] : 8'h00;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        seg_in = {8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10};

        // Full mask, scan from reset
        digit_mask = 6'b111111;
        en = 1'b1;
        do_reset();
        en = 1'b0;
        chk("rst_sel", sel, 0);
        chk("rst_an", an, 6'h3F);
        chk("rst_seg", seg_out, 8'h00);
        chk("rst_fs", frame_start, 1'b0);
        en = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            tick();
            s = (e / 4) % 6;
            act = (e % 4) >= 1;
            chk("full_sel", sel, s);
            chk("full_an", an, an_exp(s, act));
            chk("full_seg", seg_out, seg_exp(s, act));
            chk("full_fs", frame_start, (e % 24) == 0);
        end

        // Sparse mask 100101 walks 0,2,5
        digit_mask = 6'b100101;
        do_reset();
        for (int e = 1; e <= 24; e++) begin
            tick();
            s = tbl[(e / 4) % 3];
            act = (e % 4) >= 1;
            chk("sparse_sel", sel, s);
            chk("sparse_an", an, an_exp(s, act));
            chk("sparse_fs", frame_start, (e % 12) == 0);
        end

        // Empty mask holds, then a single digit reselects itself
        digit_mask = 6'b000000;
        do_reset();
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk("empty_sel", sel, 0);
            chk("empty_an", an, 6'h3F);
            chk("empty_seg", seg_out, 8'h00);
            chk("empty_fs", frame_start, 1'b0);
        end
        digit_mask = 6'b001000;
        for (int e = 11; e <= 21; e++) begin
            tick();
            s = (e >= 12) ? 3 : 0;
            act = (e >= 13) && ((e % 4) != 0);
            chk("single_sel", sel, s);
            chk("single_an", an, an_exp(s, act));
            chk("single_seg", seg_out, seg_exp(s, act));
            chk("single_fs", frame_start, (e >= 16) && ((e % 4) == 0));
        end

        // Segment pass-through with one-cycle latency
        digit_mask = 6'b111111;
        seg_in[16 +: 8] = 8'hA5;
        do_reset();
        repeat (9) tick();
        chk("seg_sel2", sel, 2);
        chk("seg_a5", seg_out, 8'hA5);
        seg_in[16 +: 8] = 8'h3C;
        tick();
        chk("seg_3c", seg_out, 8'h3C);
        seg_in[16 +: 8] = 8'h12;

        // Enable drop at pcnt=2 freezes the slot
        do_reset();
        repeat (2) tick();
        chk("en_pre_an", an, 6'h3E);
        en = 1'b0;
        for (int e = 3; e <= 7; e++) begin
            tick();
            chk("en_off_an", an, 6'h3F);
            chk("en_off_sel", sel, 0);
            chk("en_off_seg", seg_out, 8'h00);
        end
        en = 1'b1;
        tick();
        chk("en_resume_sel", sel, 0);
        chk("en_resume_an", an, 6'h3E);
        tick();
        chk("en_bound_sel", sel, 1);
        chk("en_bound_an", an, 6'h3F);

        // Reset mid-slot on digit 4, with en held high
        do_reset();
        repeat (17) tick();
        chk("cr_pre_sel", sel, 4);
        chk("cr_pre_an", an, 6'h2F);
        CR = 1'b1;
        tick();
        CR = 1'b0;
        chk("cr_sel", sel, 0);
        chk("cr_an", an, 6'h3F);
        chk("cr_seg", seg_out, 8'h00);
        chk("cr_fs", frame_start, 1'b0);
        tick();
        chk("cr_restart_an", an, 6'h3E);
        chk("cr_restart_seg", seg_out, 8'h10);
        repeat (2) tick();
        chk("cr_hold_sel", sel, 0);
        tick();
        chk("cr_next_sel", sel, 1);

        // Current digit masked mid-slot
        digit_mask = 6'b111111;
        do_reset();
        tick();
        chk("mm_pre_an", an, 6'h3E);
        digit_mask = 6'b111110;
        tick();
        chk("mm_an", an, 6'h3F);
        chk("mm_sel", sel, 0);
        chk("mm_seg", seg_out, 8'h00);
        repeat (2) tick();
        chk("mm_sel1", sel, 1);
        chk("mm_fs", frame_start, 1'b0);
        tick();
        chk("mm_an1", an, 6'h3D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Parametrised time-multiplexed digit scan controller for the multi-digit seven-segment clock display. It divides `CLK_12` into per-digit scan slots, walks a digit-select index across only the enabled digits, and drives one-hot anode enables and the selected digit's segment pattern. A programmable blanking guard at the start of each slot suppresses ghosting. It is the generalised successor of the fixed 6-digit, fixed-period selector; it adds a mask, an enable, blanking, anode decode and a frame marker.

## Interface
Parameters:
- `NUM_DIGITS`, 6: number of display digits, 2..16.
- `SEL_W`, 3: width of `sel`; must satisfy 2^SEL_W ≥ NUM_DIGITS.
- `SEG_W`, 8: segment bits per digit (7 segments + dp).
- `PRESCALE`, 128: clock cycles per digit slot, ≥ 2.
- `BLANK_CYCLES`, 8: anode-off cycles at the start of each slot, 0 ≤ BLANK_CYCLES < PRESCALE.
- `AN_ACTIVE_LOW`, 1: 1 means an active anode is driven 0.

Ports:
- `CLK_12`  in  1  system clock; all logic is on its rising edge.
- `CR`  in  1  reset, synchronous, active-high.
- `en`  in  1  scan enable.
- `digit_mask`  in  NUM_DIGITS  digit enables; bit i=1 means digit i is scanned.
- `seg_in`  in  NUM_DIGITS*SEG_W  packed segment patterns; digit i occupies bits [i*SEG_W +: SEG_W].
- `sel`  out  SEL_W  index of the current digit.
- `an`  out  NUM_DIGITS  one-hot anode enables, polarity set by AN_ACTIVE_LOW.
- `seg_out`  out  SEG_W  segment pattern of digit `sel`.
- `frame_start`  out  1  one-cycle pulse at the start of each frame.

## Operation
- Prescaler `pcnt` counts 0..PRESCALE-1 and wraps to 0. It advances only while `en`=1 and holds while `en`=0.
- Slot boundary: the cycle in which `pcnt`=PRESCALE-1 and `en`=1. At a boundary, `sel` loads the next enabled digit, searching circularly from sel+1.
  - If `sel` is the only enabled digit, it reselects itself.
  - If `digit_mask`=0, `sel` holds.
- Anode: the bit for `sel` is active when all of the following are true; otherwise every anode is inactive:
  - `en`=1;
  - `digit_mask[sel]`=1;
  - `pcnt` ≥ BLANK_CYCLES.
- `seg_out` is the registered slice of `seg_in` for `sel`. It is forced to 0 whenever the anode is inactive.
- `frame_start` pulses for one cycle when a boundary moves `sel` to an index less than or equal to its previous value (circular wrap). It also pulses on a boundary that reselects the only enabled digit. It never pulses while `digit_mask`=0.
- Masked mid-slot: if the current digit's mask bit drops, its anode goes inactive on the next edge. `sel` moves only at the next boundary.
- Mask changes take effect at the next boundary search. Disabled digits are never selected.
- Reset (`CR`=1, any cycle, including mid-slot): next edge gives `pcnt`=0, `sel`=0, all anodes inactive, `seg_out`=0, `frame_start`=0.
  - After reset, digit 0 is scanned first if its mask bit is set.
  - If digit 0 is masked, it stays blanked until the first boundary.
- `CR` has priority over `en`.

## Timing
- All outputs are registered. `sel`, `an` and `seg_out` change on the same edge.
- Latency from `seg_in` to `seg_out` is 1 cycle.
- Slot length is exactly PRESCALE enabled cycles. The anode is active for PRESCALE−BLANK_CYCLES of them, the trailing part of the slot.
- With k enabled digits and continuous `en`, the frame period is k·PRESCALE cycles and `frame_start` has that period.
- When `en` is 1→0: the anode goes inactive on the next edge and `pcnt` freezes. When `en` returns to 1, the slot resumes from the frozen count.
- `frame_start` is asserted in the same cycle that the new `sel` appears.

## Structure
- Shared package / include `display_pkg`: defaults for NUM_DIGITS and SEG_W, the blank segment pattern, and the anode-polarity helper function.
- Sub-module `scan_next_sel`: combinational circular priority search. Inputs are `sel` and `digit_mask`; outputs are the next index and a `wrapped` flag.
- All state (`pcnt`, `sel`, `an`, `seg_out`, `frame_start`) lives in `display_scan_ctrl`.

## Test plan
Default bench settings are NUM_DIGITS=6, PRESCALE=4, BLANK_CYCLES=1, AN_ACTIVE_LOW=1.
- Full mask 6'b111111, `en`=1 from reset → `sel` steps 0,1,2,3,4,5,0 every 4 cycles. `an` is 6'b111111 for 1 cycle, then has a single 0 at bit `sel` for 3 cycles. `frame_start` pulses every 24 cycles.
- Mask 6'b100101 → `sel` sequence 0,2,5,0. Frame period is 12 cycles and digits 1, 3, 4 are never selected.
- Mask 6'b000000 → `sel` holds, `an`=6'b111111, `seg_out`=0, `frame_start` never pulses. Then set mask 6'b001000 → `sel`=3 at the next boundary and `frame_start` pulses every 4 cycles.
- `seg_in` digit 2 = 8'hA5 while `sel`=2 and unblanked → `seg_out`=8'hA5. Change digit 2 to 8'h3C mid-slot → `seg_out`=8'h3C one cycle later.
- Drop `en` at `pcnt`=2 for 5 cycles → all anodes go inactive and `sel` and `pcnt` freeze. After re-enable, the boundary occurs 2 cycles later.
- Assert `CR` mid-slot with `sel`=4 → next edge gives `sel`=0, `pcnt`=0, `an`=6'b111111, `seg_out`=0. Scanning then restarts at digit 0.
